// File: rtl/serneg_pkg.sv
// Shared definitions for the bit-serial two's complement negation link.
//
// Contents:
//   SERNEG_WIDTH : default number of bits per serial word
//   rx_state_t   : receiver states (IDLE, RECV, HOLD)
package serneg_pkg;

    localparam int SERNEG_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } rx_state_t;

endpackage : serneg_pkg

// File: rtl/serial_negate_cell.sv
// Bit-serial two's complement negation cell (LSB first).
//
// The cell copies input bits up to and including the first '1'. After that
// point it inverts every following bit. This produces -x mod 2^N. The same
// cell is meant to be reused on the transmit side.
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high
//   bit_en    : the current bit is consumed; seen_one is updated
//   bit_start : the current bit is bit 0 of a word; seen_one is evaluated as 0
//   in_bit    : serial input bit
//   out_bit   : negated output bit (combinational)
//   seen_one  : seen_one value used for the current bit (after the start clear)
module serial_negate_cell (
    input  logic clk,
    input  logic reset,
    input  logic bit_en,
    input  logic bit_start,
    input  logic in_bit,
    output logic out_bit,
    output logic seen_one
);

    logic seen_one_reg;
    logic seen_one_next;

    // A start bit always begins a fresh word.
    // It must see seen_one=0 no matter what the previous word left behind.
    assign seen_one      = bit_start ? 1'b0 : seen_one_reg;
    assign out_bit       = in_bit ^ seen_one;
    assign seen_one_next = seen_one | in_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_one_reg <= 1'b0;
        end else if (bit_en) begin
            seen_one_reg <= seen_one_next;
        end
    end

endmodule : serial_negate_cell

// File: rtl/serial_negate_rx.sv
// Receive end of the bit-serial two's complement link.
//
// The block accepts an LSB-first serial word and negates it bit-serially.
// The result is shifted into a parallel word. That word is presented on a
// valid/ready port, together with an overflow flag for the one input whose
// negation is not representable (1000..0).
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high
//   in_valid  : in_bit / in_start carry a bit this cycle
//   in_start  : marks bit 0 (LSB) of a word
//   in_bit    : serial data bit, LSB first
//   in_ready  : block can accept a bit this cycle (low only in HOLD)
//   out_valid : out_data / out_ovf hold a completed word
//   out_ready : consumer takes the word this cycle
//   out_data  : -(received word) mod 2^WIDTH
//   out_ovf   : received word was 1000..0
//   frame_err : one-cycle pulse on a framing violation
module serial_negate_rx
    import serneg_pkg::*;
#(
    parameter int WIDTH = SERNEG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    rx_state_t        state_reg,     state_next;
    logic [CW-1:0]    count_reg,     count_next;
    logic [WIDTH-1:0] shift_reg,     shift_next;
    logic [WIDTH-1:0] out_data_reg,  out_data_next;
    logic             out_ovf_reg,   out_ovf_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_err_reg, frame_err_next;

    logic             accept;
    logic             cell_en;
    logic             neg_bit;
    logic             seen_one;
    logic [WIDTH-1:0] shifted;

    serial_negate_cell u_cell (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (cell_en),
        .bit_start (in_start),
        .in_bit    (in_bit),
        .out_bit   (neg_bit),
        .seen_one  (seen_one)
    );

    assign in_ready  = (state_reg != HOLD);
    assign accept    = in_valid && in_ready;
    // New bits enter at the MSB end. After WIDTH shifts, the first bit
    // received ends up in bit 0.
    assign shifted   = {neg_bit, shift_reg[WIDTH-1:1]};

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign frame_err = frame_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            out_data_reg  <= out_data_next;
            out_ovf_reg   <= out_ovf_next;
            out_valid_reg <= out_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        out_data_next  = out_data_reg;
        out_ovf_next   = out_ovf_reg;
        out_valid_next = out_valid_reg;
        frame_err_next = 1'b0;
        cell_en        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (in_start) begin
                        cell_en    = 1'b1;
                        shift_next = shifted;
                        count_next = ONE;
                        state_next = RECV;
                    end else begin
                        // A bit that arrives without a word start is dropped.
                        // It must not disturb seen_one.
                        frame_err_next = 1'b1;
                    end
                end
            end

            RECV: begin
                if (accept) begin
                    cell_en    = 1'b1;
                    shift_next = shifted;
                    if (in_start) begin
                        // Restart: drop the partial word, keep this bit as bit 0.
                        frame_err_next = 1'b1;
                        count_next     = ONE;
                    end else if (count_reg == LAST_IDX) begin
                        out_data_next  = shifted;
                        // The only input with no '1' before its MSB, and a '1'
                        // in the MSB itself, is 10..0.
                        out_ovf_next   = in_bit & ~seen_one;
                        out_valid_next = 1'b1;
                        count_next     = '0;
                        state_next     = HOLD;
                    end else begin
                        count_next = count_reg + ONE;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule : serial_negate_rx

// File: tb/tb_serial_negate_rx.sv
module tb_serial_negate_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_start;
    logic         in_bit;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         frame_err;

    serial_negate_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
        logic         exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fe_count    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Output monitor: each handshake pops the scoreboard and is compared.
    always @(negedge clk) begin
        if (frame_err) begin
            fe_count++;
            vectors++;
            if (out_valid) begin
                miscompares++;
                $display("FAIL frame_err_in_hold: frame_err=1 with out_valid=1, required frame_err=0");
            end
        end
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (scoreboard.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got data=0x%0h ovf=%0b, required no output", out_data, out_ovf);
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                if (out_data !== e.data || out_ovf !== e.ovf) begin
                    miscompares++;
                    $display("FAIL word: got data=0x%0h ovf=%0b, required data=0x%0h ovf=%0b",
                             out_data, out_ovf, e.data, e.ovf);
                end else begin
                    $display("ok   word: data=0x%0h ovf=%0b", out_data, out_ovf);
                end
            end
        end
    end

    // Drive one bit and wait (bounded) until it is accepted.
    task automatic send_bit(input logic s, input logic b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_start = s;
        in_bit   = b;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Send a full word. The expected result is pushed just before the last bit.
    task automatic send_word(input logic [W-1:0] w, input logic push,
                             input logic [W-1:0] ed, input logic eo, input int gap);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1 && push) scoreboard.push_back('{data: ed, ovf: eo});
            send_bit(i == 0, w[i]);
            if (gap > 0 && i != W - 1) idle_cycles(gap);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   fe0;

        tbl[0] = '{word: 8'h05, exp_data: 8'hFB, exp_ovf: 1'b0};
        tbl[1] = '{word: 8'h00, exp_data: 8'h00, exp_ovf: 1'b0};
        tbl[2] = '{word: 8'h80, exp_data: 8'h80, exp_ovf: 1'b1};
        tbl[3] = '{word: 8'hFF, exp_data: 8'h01, exp_ovf: 1'b0};
        tbl[4] = '{word: 8'h7F, exp_data: 8'h81, exp_ovf: 1'b0};
        tbl[5] = '{word: 8'h10, exp_data: 8'hF0, exp_ovf: 1'b0};
        tbl[6] = '{word: 8'h01, exp_data: 8'hFF, exp_ovf: 1'b0};
        tbl[7] = '{word: 8'hC0, exp_data: 8'h40, exp_ovf: 1'b0};
        tbl[8] = '{word: 8'h5A, exp_data: 8'hA6, exp_ovf: 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        idle_cycles(3);
        check_reset_state("reset");
        reset = 1'b0;
        idle_cycles(1);

        // Table-driven words, with gaps on every other entry.
        for (int i = 0; i < 9; i++) begin
            send_word(tbl[i].word, 1'b1, tbl[i].exp_data, tbl[i].exp_ovf, i % 2);
        end
        idle_cycles(2);

        // Backpressure: 0x01 -> 0xFF held while out_ready is low.
        out_ready = 1'b0;
        send_word(8'h01, 1'b1, 8'hFF, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'hFF);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);

        // Restart mid-word: 3 bits of 0x07, then word 0x02 with gaps.
        fe0 = fe_count;
        send_bit(1'b1, 1'b1);
        idle_cycles(1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        idle_cycles(2);
        send_word(8'h02, 1'b1, 8'hFE, 1'b0, 2);
        idle_cycles(2);
        check("restart_frame_err_pulses", 32'(fe_count - fe0), 32'd1);

        // Stray bit in IDLE, then a proper 0x10.
        fe0 = fe_count;
        send_bit(1'b0, 1'b1);
        idle_cycles(2);
        check("stray_frame_err_pulses", 32'(fe_count - fe0), 32'd1);
        check("stray_no_out_valid",     32'(out_valid),      32'd0);
        send_word(8'h10, 1'b1, 8'hF0, 1'b0, 0);
        idle_cycles(2);

        // Reset after 4 bits.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        #2 reset = 1'b1;
        #1 check_reset_state("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(1);

        // Reset while a word is held.
        out_ready = 1'b0;
        send_word(8'h05, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        check("hold_before_reset_valid", 32'(out_valid), 32'd1);
        check("hold_before_reset_data",  32'(out_data),  32'hFB);
        #2 reset = 1'b1;
        #1 check_reset_state("rst_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        idle_cycles(1);
        send_word(8'h03, 1'b1, 8'hFD, 1'b0, 0);
        idle_cycles(3);

        check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_negate_rx

// File: doc/serial_negate_rx.md
Name: serial_negate_rx

Overview:
Receive end of the bit-serial two's complement link. Accepts an LSB-first serial stream of WIDTH-bit words and negates each word bit-serially, restoring the original value. Shifts the result into a parallel word and presents it on a valid/ready output port. Sits between the serial negating transmitter and any parallel-word consumer.

Parameters:
WIDTH, 8, bits per serial word; legal range 2..32.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clock clk
in_valid  input  1  in_bit (and in_start) carry a bit this cycle
in_start  input  1  qualifies the first (LSB) bit of a word; ignored unless in_valid
in_bit  input  1  serial data bit, LSB first
in_ready  output  1  block can accept a bit this cycle
out_valid  output  1  out_data/out_ovf hold a completed word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  WIDTH  negated word, i.e. -(received word) mod 2^WIDTH
out_ovf  output  1  received word was 1000..0 (negation not representable)
frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Bit accepted on a rising edge when in_valid && in_ready.
- in_ready = (state != HOLD). This is combinational from state only.
- States are IDLE, RECV and HOLD. Reset enters IDLE.
- Reset values: out_valid=0, out_data=0, out_ovf=0, frame_err=0, bit counter=0, seen_one=0.
- Negation cell, per accepted bit:
  - out_bit = in_bit XOR seen_one.
  - seen_one_next = seen_one OR in_bit.
  - seen_one is forced to 0 on any accepted bit with in_start=1 before evaluation, so that start bit uses seen_one=0.
- Shift: out_bit enters the shift register at the MSB end, with a right shift each accepted bit. After WIDTH bits, bit 0 is the first received bit.
- IDLE:
  - Accepted bit with in_start=1: store bit 0, count=1, go to RECV.
  - Accepted bit with in_start=0: bit dropped, frame_err pulses, stay IDLE.
- RECV:
  - Accepted bit with in_start=0: store the bit, count++.
  - When the accepted bit is bit WIDTH-1 (count==WIDTH-1): load out_data from the full shift value and set out_valid=1 on that same edge.
  - out_ovf = (in_bit==1 && seen_one==0) for that last bit, i.e. the input was 10..0. Go to HOLD.
  - Accepted bit with in_start=1 mid-word: frame_err pulses and the partial word is discarded. The bit is treated as bit 0 of a new word (count=1, seen_one from this bit), stay RECV.
  - in_valid=0: no change, gaps allowed.
- HOLD:
  - out_valid=1; out_data and out_ovf stable.
  - out_ready=1: out_valid=0 on next edge, go to IDLE.
  - Input is not accepted (in_ready=0); the sender must hold.
- Latency: out_valid rises on the clock edge that accepts the last bit. The earliest next word's first bit is accepted on the edge after the out_ready handshake edge.
- WIDTH=1-style degenerate cases are excluded. The counter is $clog2(WIDTH+1) bits and does not wrap.
- frame_err is high for exactly one cycle per violation and is never asserted in HOLD.
- Reset mid-word or in HOLD: immediate return to reset values; the partial or held word is lost.
- Zero word: all bits 0, seen_one stays 0, out_data=0, out_ovf=0.

Decomposition:
- Shared package serneg_pkg:
  - typedef enum logic [1:0] {IDLE, RECV, HOLD} rx_state_t
  - WIDTH default constant
- Sub-module serial_negate_cell:
  - Holds the seen_one flop with synchronous clear on start.
  - Combinational out_bit.
  - Reused later by the transmitter side.

Test Plan:
- WIDTH=8, send 0x05 (bits 1,0,1,0,0,0,0,0) with in_start on first bit, out_ready=1 → out_valid one cycle, out_data=0xFB, out_ovf=0.
- Send 0x00 → out_data=0x00, out_ovf=0. Then send 0x80 → out_data=0x80, out_ovf=1. Then send 0xFF → out_data=0x01.
- Backpressure: send 0x01 with out_ready=0 for 5 cycles → out_valid and out_data=0xFF held, in_ready=0 throughout. Release → out_valid drops next edge, in_ready=1.
- Restart mid-word: 3 bits of 0x07, then in_start with word 0x02 → frame_err single pulse, out_data=0xFE. Also in_valid gaps inserted between bits → result unchanged.
- Stray bit in IDLE with in_start=0 → frame_err pulse, no out_valid. The next proper word 0x10 → 0xF0.
- Assert reset after 4 bits and again during HOLD → all outputs return to 0 and state to IDLE. The following word 0x03 → 0xFD.
